// File: rtl/rom_dl_bridge_if.sv
// Bus bundle between data_io, the ROM download bridge and the two sdram write ports.
// slave: the bridge's view. master: the data_io/sdram side.
interface rom_dl_bridge_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        port1_req, port1_ack, port1_we;
  logic [22:0] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;
  logic        port2_req, port2_ack, port2_we;
  logic [22:0] port2_a;
  logic [1:0]  port2_ds;
  logic [15:0] port2_d;
  logic        rom_loaded, dl_busy, overflow;

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  port1_ack, port2_ack,
    output port1_req, port1_a, port1_ds, port1_we, port1_d,
    output port2_req, port2_a, port2_ds, port2_we, port2_d,
    output rom_loaded, dl_busy, overflow
  );

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output port1_ack, port2_ack,
    input  port1_req, port1_a, port1_ds, port1_we, port1_d,
    input  port2_req, port2_a, port2_ds, port2_we, port2_d,
    input  rom_loaded, dl_busy, overflow
  );
endinterface

// File: rtl/rom_dl_bridge.sv
// ROM download bridge: buffers data_io bytes in a small FIFO and issues them as
// ack-checked toggle-handshake writes to sdram port 1 (raw address) and port 2
// (address rebased by GFX_BASE). Produces the sticky rom_loaded flag.
// Optional build macro ROMDL_PORT2_FILTER_EN: when defined, only bytes at or
// above GFX_BASE are written to port 2; otherwise every byte goes to both ports.
module rom_dl_bridge #(
  parameter logic [24:0] GFX_BASE  = 25'h0E000,
  parameter int          FIFO_AW   = 2,
  parameter logic [7:0]  ROM_INDEX = 8'd0
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  rom_dl_bridge_if.slave  bus
);

  localparam int DEPTH = 1 << FIFO_AW;

  // Port-2 selection is resolved at push time, so only 24 address bits are kept.
  typedef struct packed {
    logic        use2;
    logic [23:0] addr;
    logic [7:0]  data;
  } ent_t;

  typedef enum logic {IDLE, WAIT} state_t;

  logic               wr_q, dl_q;
  ent_t               mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  state_t             state_q;
  logic               dl_done_q, loaded_q, ovf_q, use2_q;
  logic               p1_req_q, p1_we_q, p2_req_q, p2_we_q;
  logic [22:0]        p1_a_q, p2_a_q;
  logic [1:0]         p1_ds_q, p2_ds_q;
  logic [15:0]        p1_d_q, p2_d_q;

  logic        accept, empty, full, pop, push, drop, dl_rise, dl_fall, ack_ok;
  ent_t        push_ent, head;
  logic [23:0] p2_addr;

  assign accept  = bus.ioctl_wr & ~wr_q & bus.ioctl_download & (bus.ioctl_index == ROM_INDEX);
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (FIFO_AW+1)'(DEPTH));
  assign pop     = (state_q == IDLE) & ~empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still legal.
  assign push    = accept & (~full | pop);
  assign drop    = accept & full & ~pop;
  assign dl_rise = bus.ioctl_download & ~dl_q;
  assign dl_fall = ~bus.ioctl_download & dl_q;
  assign head    = mem_q[rptr_q];
  // Low 24 bits of the modulo-2^25 difference are all that reach the port.
  assign p2_addr = head.addr - GFX_BASE[23:0];
  assign ack_ok  = (bus.port1_ack == p1_req_q) & (~use2_q | (bus.port2_ack == p2_req_q));

  // Build the FIFO entry from the current data_io byte.
  always_comb begin
    push_ent.addr = bus.ioctl_addr[23:0];
    push_ent.data = bus.ioctl_dout;
`ifdef ROMDL_PORT2_FILTER_EN
    push_ent.use2 = (bus.ioctl_addr >= GFX_BASE);
`else
    push_ent.use2 = 1'b1;
`endif
  end

  // Next FIFO occupancy.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  // Registered copies of the strobe and download level for edge detection.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= 1'b0;
      dl_q <= 1'b0;
    end else begin
      wr_q <= bus.ioctl_wr;
      dl_q <= bus.ioctl_download;
    end
  end

  // FIFO storage; contents are meaningless while empty so no reset is needed.
  always_ff @(posedge clk_sys) begin
    if (push) mem_q[wptr_q] <= push_ent;
  end

  // FIFO pointers and count.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Issue FSM with registered port outputs, plus the download status flags.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      use2_q    <= 1'b0;
      p1_req_q  <= 1'b0;
      p1_we_q   <= 1'b0;
      p1_a_q    <= '0;
      p1_ds_q   <= '0;
      p1_d_q    <= '0;
      p2_req_q  <= 1'b0;
      p2_we_q   <= 1'b0;
      p2_a_q    <= '0;
      p2_ds_q   <= '0;
      p2_d_q    <= '0;
      dl_done_q <= 1'b0;
      loaded_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (pop) begin
          use2_q   <= head.use2;
          p1_a_q   <= head.addr[23:1];
          p1_ds_q  <= {head.addr[0], ~head.addr[0]};
          p1_d_q   <= {head.data, head.data};
          p1_req_q <= ~p1_req_q;
          p1_we_q  <= 1'b1;
          if (head.use2) begin
            p2_a_q   <= p2_addr[23:1];
            p2_ds_q  <= {p2_addr[0], ~p2_addr[0]};
            p2_d_q   <= {head.data, head.data};
            p2_req_q <= ~p2_req_q;
            p2_we_q  <= 1'b1;
          end
          state_q <= WAIT;
        end
        WAIT: if (ack_ok) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      // A new download start wins over completion in the same cycle.
      if (dl_rise) begin
        dl_done_q <= 1'b0;
        loaded_q  <= 1'b0;
      end else begin
        if (dl_fall) dl_done_q <= 1'b1;
        // Empty and idle excludes a pop this cycle, so we never set and clear together.
        if (dl_done_q && empty && state_q == IDLE) begin
          loaded_q <= 1'b1;
          p1_we_q  <= 1'b0;
          p2_we_q  <= 1'b0;
        end
      end

      if (dl_rise) ovf_q <= 1'b0;
      if (drop)    ovf_q <= 1'b1;
    end
  end

  assign bus.port1_req  = p1_req_q;
  assign bus.port1_we   = p1_we_q;
  assign bus.port1_a    = p1_a_q;
  assign bus.port1_ds   = p1_ds_q;
  assign bus.port1_d    = p1_d_q;
  assign bus.port2_req  = p2_req_q;
  assign bus.port2_we   = p2_we_q;
  assign bus.port2_a    = p2_a_q;
  assign bus.port2_ds   = p2_ds_q;
  assign bus.port2_d    = p2_d_q;
  assign bus.rom_loaded = loaded_q;
  assign bus.overflow   = ovf_q;
  // Stays busy after the download ends until rom_loaded registers, so the two
  // flags change on the same edge.
  assign bus.dl_busy    = dl_q | ~empty | (state_q == WAIT) | (dl_done_q & ~loaded_q);

endmodule

// File: tb/tb_rom_dl_bridge.sv
`timescale 1ns/1ps
module tb_rom_dl_bridge;
  localparam logic [24:0] GFX_BASE = 25'h0E000;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  rom_dl_bridge_if bus();
  rom_dl_bridge #(.GFX_BASE(GFX_BASE), .FIFO_AW(2), .ROM_INDEX(8'd0)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int ack_dly = 0;

  // sdram ack model: returns the ack toggle ack_dly cycles after seeing a request.
  logic a1, a2;
  int   c1, c2;
  assign bus.port1_ack = a1;
  assign bus.port2_ack = a2;
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      a1 <= 1'b0; c1 <= 0; a2 <= 1'b0; c2 <= 0;
    end else begin
      if (bus.port1_req != a1) begin
        if (c1 >= ack_dly) begin a1 <= bus.port1_req; c1 <= 0; end else c1 <= c1 + 1;
      end else c1 <= 0;
      if (bus.port2_req != a2) begin
        if (c2 >= ack_dly) begin a2 <= bus.port2_req; c2 <= 0; end else c2 <= c2 + 1;
      end else c2 <= 0;
    end
  end

  // Write monitor: every req toggle captures {a, ds, d}.
  logic [40:0] obs1[$], obs2[$], exp1[$], exp2[$];
  logic pr1 = 1'b0, pr2 = 1'b0;
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      pr1 <= 1'b0; pr2 <= 1'b0;
    end else begin
      if (bus.port1_req != pr1) obs1.push_back({bus.port1_a, bus.port1_ds, bus.port1_d});
      if (bus.port2_req != pr2) obs2.push_back({bus.port2_a, bus.port2_ds, bus.port2_d});
      pr1 <= bus.port1_req;
      pr2 <= bus.port2_req;
    end
  end

  // Reference: what a byte should look like on each port.
  function automatic logic [40:0] e1(input logic [24:0] ad, input logic [7:0] d);
    return {ad[23:1], ad[0], ~ad[0], d, d};
  endfunction
  function automatic logic [40:0] e2(input logic [24:0] ad, input logic [7:0] d);
    logic [24:0] r;
    r = ad - GFX_BASE;
    return {r[23:1], r[0], ~r[0], d, d};
  endfunction
  function automatic bit uses2(input logic [24:0] ad);
`ifdef ROMDL_PORT2_FILTER_EN
    return ad >= GFX_BASE;
`else
    return 1'b1;
`endif
  endfunction

  task automatic expect_byte(input logic [24:0] ad, input logic [7:0] d);
    exp1.push_back(e1(ad, d));
    if (uses2(ad)) exp2.push_back(e2(ad, d));
  endtask

  task automatic clear_q();
    obs1.delete(); obs2.delete(); exp1.delete(); exp2.delete();
  endtask

  task automatic send(input logic [24:0] ad, input logic [7:0] d, input int hold, input logic [7:0] idx);
    @(negedge clk_sys);
    bus.ioctl_addr = ad; bus.ioctl_dout = d; bus.ioctl_index = idx; bus.ioctl_wr = 1'b1;
    repeat (hold) @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic start_dl();
    @(negedge clk_sys); bus.ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
    bus.ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  // Bounded wait until every expected write has been issued and acknowledged.
  task automatic wait_drain(input int budget, input string nm);
    int n = 0;
    while (!(obs1.size() >= exp1.size() && obs2.size() >= exp2.size() &&
             a1 === bus.port1_req && a2 === bus.port2_req) && n < budget) begin
      @(posedge clk_sys); n++;
    end
    repeat (3) @(posedge clk_sys);
    #1;
    checks++;
    if (n >= budget) begin errors++; $display("FAIL %s_timeout got %0d writes exp %0d", nm, obs1.size(), exp1.size()); end
  endtask

  task automatic test_reset();
    bus.ioctl_download = 1'b0; bus.ioctl_index = 8'd0; bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = '0; bus.ioctl_dout = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    checks++; if (bus.port1_req !== 1'b0)  begin errors++; $display("FAIL rst_req1 got %b exp 0", bus.port1_req); end
    checks++; if (bus.port2_req !== 1'b0)  begin errors++; $display("FAIL rst_req2 got %b exp 0", bus.port2_req); end
    checks++; if (bus.port1_we !== 1'b0)   begin errors++; $display("FAIL rst_we1 got %b exp 0", bus.port1_we); end
    checks++; if (bus.port2_we !== 1'b0)   begin errors++; $display("FAIL rst_we2 got %b exp 0", bus.port2_we); end
    checks++; if (bus.rom_loaded !== 1'b0) begin errors++; $display("FAIL rst_loaded got %b exp 0", bus.rom_loaded); end
    checks++; if (bus.dl_busy !== 1'b0)    begin errors++; $display("FAIL rst_busy got %b exp 0", bus.dl_busy); end
    checks++; if (bus.overflow !== 1'b0)   begin errors++; $display("FAIL rst_ovf got %b exp 0", bus.overflow); end
    @(negedge clk_sys); reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_single();
    clear_q(); ack_dly = 3;
    start_dl();
    expect_byte(25'h00003, 8'hA5);
    bus.ioctl_addr = 25'h00003; bus.ioctl_dout = 8'hA5; bus.ioctl_index = 8'd0; bus.ioctl_wr = 1'b1;
    @(posedge clk_sys); #1;
    checks++; if (bus.port1_req !== 1'b0) begin errors++; $display("FAIL lat_edge_n got %b exp 0", bus.port1_req); end
    @(posedge clk_sys); #1;
    checks++; if (bus.port1_req !== 1'b1) begin errors++; $display("FAIL lat_edge_n1 got %b exp 1", bus.port1_req); end
    checks++; if (bus.port1_we !== 1'b1)  begin errors++; $display("FAIL single_we1 got %b exp 1", bus.port1_we); end
    @(negedge clk_sys); bus.ioctl_wr = 1'b0;
    wait_drain(100, "single");
    checks++; if (obs1.size() != 1) begin errors++; $display("FAIL single_n1 got %0d exp 1", obs1.size()); end
    checks++; if (obs1.size() > 0 && obs1[0] !== {23'h000001, 2'b10, 16'hA5A5})
      begin errors++; $display("FAIL single_p1 got %h exp %h", obs1[0], {23'h000001, 2'b10, 16'hA5A5}); end
`ifdef ROMDL_PORT2_FILTER_EN
    checks++; if (obs2.size() != 0) begin errors++; $display("FAIL single_p2_untouched got %0d exp 0", obs2.size()); end
`else
    checks++; if (obs2.size() != 1 || obs2[0] !== e2(25'h00003, 8'hA5))
      begin errors++; $display("FAIL single_p2 got %0d writes exp 1 of %h", obs2.size(), e2(25'h00003, 8'hA5)); end
`endif
  endtask

  task automatic test_gfx();
    clear_q(); ack_dly = 2;
    expect_byte(25'h0E001, 8'h3C);
    send(25'h0E001, 8'h3C, 1, 8'd0);
    wait_drain(100, "gfx");
    checks++; if (obs1.size() != 1 || obs1[0] !== {23'h007000, 2'b10, 16'h3C3C})
      begin errors++; $display("FAIL gfx_p1 got %0d writes exp 1 of %h", obs1.size(), {23'h007000, 2'b10, 16'h3C3C}); end
    checks++; if (obs2.size() != 1 || obs2[0] !== {23'h000000, 2'b10, 16'h3C3C})
      begin errors++; $display("FAIL gfx_p2 got %0d writes exp 1 of %h", obs2.size(), {23'h000000, 2'b10, 16'h3C3C}); end
  endtask

  task automatic test_hold();
    clear_q(); ack_dly = 0;
    expect_byte(25'h10042, 8'h5A);
    send(25'h10042, 8'h5A, 4, 8'd0);
    wait_drain(100, "hold");
    checks++; if (obs1.size() != 1) begin errors++; $display("FAIL hold_count got %0d exp 1", obs1.size()); end
    checks++; if (obs1.size() > 0 && obs1[0] !== exp1[0]) begin errors++; $display("FAIL hold_data got %h exp %h", obs1[0], exp1[0]); end
  endtask

  task automatic test_overflow();
    clear_q(); ack_dly = 40;
    start_dl();
    expect_byte(25'h0E100, 8'h11);
    send(25'h0E100, 8'h11, 1, 8'd0);
    repeat (3) @(negedge clk_sys);
    #1;
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre got %b exp 0", bus.overflow); end
    for (int i = 0; i < 6; i++) begin
      logic [24:0] ad;
      ad = 25'h0E200 + 25'(i * 3);
      if (i < 4) expect_byte(ad, 8'(8'h20 + i));
      send(ad, 8'(8'h20 + i), 1, 8'd0);
    end
    @(posedge clk_sys); #1;
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", bus.overflow); end
    wait_drain(1000, "ovf");
    checks++; if (obs1.size() != exp1.size()) begin errors++; $display("FAIL ovf_n1 got %0d exp %0d", obs1.size(), exp1.size()); end
    foreach (exp1[i]) begin
      checks++;
      if (i >= obs1.size() || obs1[i] !== exp1[i]) begin errors++; $display("FAIL ovf_order1[%0d] exp %h", i, exp1[i]); end
    end
    foreach (exp2[i]) begin
      checks++;
      if (i >= obs2.size() || obs2[i] !== exp2[i]) begin errors++; $display("FAIL ovf_order2[%0d] exp %h", i, exp2[i]); end
    end
  endtask

  task automatic test_idle_done();
    @(negedge clk_sys); bus.ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
    checks++; if (bus.rom_loaded !== 1'b0) begin errors++; $display("FAIL idle_fall_edge got %b exp 0", bus.rom_loaded); end
    @(posedge clk_sys); #1;
    checks++; if (bus.rom_loaded !== 1'b1) begin errors++; $display("FAIL idle_loaded got %b exp 1", bus.rom_loaded); end
    checks++; if (bus.dl_busy !== 1'b0)    begin errors++; $display("FAIL idle_busy got %b exp 0", bus.dl_busy); end
    checks++; if (bus.port1_we !== 1'b0)   begin errors++; $display("FAIL idle_we1 got %b exp 0", bus.port1_we); end
    @(negedge clk_sys); bus.ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    checks++; if (bus.rom_loaded !== 1'b0) begin errors++; $display("FAIL restart_loaded got %b exp 0", bus.rom_loaded); end
    checks++; if (bus.overflow !== 1'b0)   begin errors++; $display("FAIL restart_ovf got %b exp 0", bus.overflow); end
  endtask

  task automatic test_drain();
    bit early = 0;
    int n = 0;
    clear_q(); ack_dly = 10;
    start_dl();
    for (int i = 0; i < 4; i++) begin
      expect_byte(25'h0F000 + 25'(i), 8'(8'h40 + i));
      send(25'h0F000 + 25'(i), 8'(8'h40 + i), 1, 8'd0);
    end
    bus.ioctl_download = 1'b0;
    while (!(obs1.size() == 4 && a1 === bus.port1_req && a2 === bus.port2_req) && n < 500) begin
      @(posedge clk_sys); #1; n++;
      if (bus.rom_loaded !== 1'b0) early = 1;
    end
    checks++; if (n >= 500) begin errors++; $display("FAIL drain_timeout got %0d writes exp 4", obs1.size()); end
    checks++; if (early) begin errors++; $display("FAIL drain_early got 1 exp 0"); end
    @(posedge clk_sys); #1;
    checks++; if (bus.rom_loaded !== 1'b0) begin errors++; $display("FAIL drain_match_edge got %b exp 0", bus.rom_loaded); end
    checks++; if (bus.dl_busy !== 1'b1)    begin errors++; $display("FAIL drain_busy_hold got %b exp 1", bus.dl_busy); end
    @(posedge clk_sys); #1;
    checks++; if (bus.rom_loaded !== 1'b1) begin errors++; $display("FAIL drain_loaded got %b exp 1", bus.rom_loaded); end
    checks++; if (bus.dl_busy !== 1'b0)    begin errors++; $display("FAIL drain_busy_fall got %b exp 0", bus.dl_busy); end
    foreach (exp1[i]) begin
      checks++;
      if (i >= obs1.size() || obs1[i] !== exp1[i]) begin errors++; $display("FAIL drain_data[%0d] exp %h", i, exp1[i]); end
    end
  endtask

  task automatic test_random();
    clear_q();
    start_dl();
    for (int i = 0; i < 24; i++) begin
      logic [24:0] ad;
      logic [7:0]  d, idx;
      int hold;
      ad   = 25'($urandom);
      d    = 8'($urandom);
      idx  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      hold = $urandom_range(1, 3);
      ack_dly = $urandom_range(0, 3);
      if (idx == 8'd0) expect_byte(ad, d);
      send(ad, d, hold, idx);
      repeat (6) @(negedge clk_sys);
    end
    wait_drain(500, "rand");
    checks++; if (obs1.size() != exp1.size()) begin errors++; $display("FAIL rand_n1 got %0d exp %0d", obs1.size(), exp1.size()); end
    checks++; if (obs2.size() != exp2.size()) begin errors++; $display("FAIL rand_n2 got %0d exp %0d", obs2.size(), exp2.size()); end
    foreach (exp1[i]) begin
      checks++;
      if (i >= obs1.size() || obs1[i] !== exp1[i]) begin errors++; $display("FAIL rand_p1[%0d] exp %h", i, exp1[i]); end
    end
    foreach (exp2[i]) begin
      checks++;
      if (i >= obs2.size() || obs2[i] !== exp2[i]) begin errors++; $display("FAIL rand_p2[%0d] exp %h", i, exp2[i]); end
    end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rand_ovf got %b exp 0", bus.overflow); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk_sys); reset_n = 1'b0; bus.ioctl_download = 1'b0;
    @(negedge clk_sys); reset_n = 1'b1;
    clear_q(); ack_dly = 50;
    start_dl();
    send(25'h0E010, 8'h77, 1, 8'd0);
    send(25'h0E011, 8'h78, 1, 8'd0);
    send(25'h0E012, 8'h79, 1, 8'd0);
    @(posedge clk_sys); #1;
    checks++; if (bus.port1_req !== 1'b1) begin errors++; $display("FAIL mid_pre_req got %b exp 1", bus.port1_req); end
    checks++; if (bus.dl_busy !== 1'b1)   begin errors++; $display("FAIL mid_pre_busy got %b exp 1", bus.dl_busy); end
    @(posedge clk_sys); #3 reset_n = 1'b0;
    #1;
    checks++; if (bus.port1_req !== 1'b0) begin errors++; $display("FAIL mid_req1 got %b exp 0", bus.port1_req); end
    checks++; if (bus.port1_we !== 1'b0)  begin errors++; $display("FAIL mid_we1 got %b exp 0", bus.port1_we); end
    checks++; if (bus.dl_busy !== 1'b0)   begin errors++; $display("FAIL mid_busy got %b exp 0", bus.dl_busy); end
    checks++; if (bus.overflow !== 1'b0 || bus.rom_loaded !== 1'b0)
      begin errors++; $display("FAIL mid_flags got %b%b exp 00", bus.overflow, bus.rom_loaded); end
    bus.ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
    clear_q();
    reset_n = 1'b1;
    repeat (10) @(posedge clk_sys);
    #1;
    checks++; if (obs1.size() != 0) begin errors++; $display("FAIL mid_fifo_empty got %0d writes exp 0", obs1.size()); end
    checks++; if (bus.dl_busy !== 1'b0) begin errors++; $display("FAIL mid_idle got %b exp 0", bus.dl_busy); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_gfx();
    test_hold();
    test_overflow();
    test_idle_done();
    test_drain();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
